// File: rtl/fetch_cycle_sequencer.sv
// Eight-phase fetch sequencer for the 4-bit CPU: drives PC nibbles, captures the
// opcode byte, strobes execute, and applies jump/call/return at cycle end.
module fetch_cycle_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 3
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [3:0]            bus_in,
  input  logic                  jump_req,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [3:0]            bus_out,
  output logic                  bus_oe,
  output logic                  sync,
  output logic [2:0]            phase,
  output logic [7:0]            instruction,
  output logic                  exec_strobe,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t                r_phase;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]       r_sp;
  logic [7:0]            r_instr;
  logic [SP_W-1:0]       w_sp_inc;
  logic [SP_W-1:0]       w_sp_dec;

  // Circular stack pointer neighbours; depth need not be a power of two
  always_comb begin
    w_sp_inc = (r_sp == SP_LAST) ? {SP_W{1'b0}} : r_sp + SP_W'(1);
    w_sp_dec = (r_sp == {SP_W{1'b0}}) ? SP_LAST : r_sp - SP_W'(1);
  end

  // Phase sequencer with PC, opcode capture and call stack; stall freezes all of it
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      r_phase <= PH_A1;
      r_pc    <= {ADDR_WIDTH{1'b0}};
      r_sp    <= {SP_W{1'b0}};
      r_instr <= 8'h00;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (!stall) begin
      r_phase <= phase_t'(r_phase + 3'd1);
      case (r_phase)
        PH_A3: r_pc <= r_pc + ADDR_WIDTH'(1);
        PH_M1: r_instr[7:4] <= bus_in;
        PH_M2: r_instr[3:0] <= bus_in;
        PH_X3: begin
          // r_pc already holds the incremented return address here
          if (ret_req) begin
            r_sp <= w_sp_dec;
            r_pc <= r_stack[w_sp_dec];
          end else if (call_req) begin
            r_stack[r_sp] <= r_pc;
            r_sp          <= w_sp_inc;
            r_pc          <= jump_addr;
          end else if (jump_req) begin
            r_pc <= jump_addr;
          end else begin
            r_pc <= r_pc;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // Output decode of the phase and PC registers
  always_comb begin
    bus_out     = 4'h0;
    bus_oe      = 1'b0;
    sync        = 1'b0;
    exec_strobe = 1'b0;
    case (r_phase)
      PH_A1: begin
        bus_out = r_pc[3:0];
        bus_oe  = 1'b1;
      end
      PH_A2: begin
        bus_out = r_pc[7:4];
        bus_oe  = 1'b1;
      end
      PH_A3: begin
        bus_out = r_pc[11:8];
        bus_oe  = 1'b1;
      end
      PH_X1:   exec_strobe = 1'b1;
      PH_X3:   sync = 1'b1;
      default: bus_out = 4'h0;
    endcase
  end

  assign phase       = r_phase;
  assign pc          = r_pc;
  assign instruction = r_instr;

endmodule

// File: doc/fetch_cycle_sequencer.md
Name: fetch_cycle_sequencer

Overview:
- 8-phase instruction-cycle sequencer for the 4-bit CPU: A1 A2 A3 M1 M2 X1 X2 X3.
- Owns the 12-bit program counter and a circular call stack.
- Drives the PC nibbles onto the multiplexed 4-bit bus, then captures the opcode nibbles from the bus.
- Presents the byte to the control unit with a one-cycle execute strobe, and applies jump/call/return requests at cycle end.

Parameters:
ADDR_WIDTH, 12, PC width; fixed as 3 nibbles, other values unsupported.
STACK_DEPTH, 3, call-stack entries; circular, 1..4 supported.

Ports:
clk_2  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low; clears all state
stall  input  1  freeze phase, PC and stack while high
bus_in  input  4  data bus sampled in M1/M2
jump_req  input  1  load PC with jump_addr at cycle end
call_req  input  1  push return PC, then load jump_addr
ret_req  input  1  pop stack into PC
jump_addr  input  12  target for jump_req/call_req
bus_out  output  4  PC nibble during A1..A3, else 0
bus_oe  output  1  high in A1, A2, A3 only
sync  output  1  high in X3 (marks next cycle = A1)
phase  output  3  current phase: A1=0 .. X3=7
instruction  output  8  latched opcode {OPR,OPA}
exec_strobe  output  1  one-cycle pulse in X1
pc  output  12  current program counter

Behaviour:
- Phase register advances by 1 mod 8 per rising clk_2 when stall=0; X3 -> A1.
- Reset (async, reset=0): phase=A1, pc=0, stack entries=0, sp=0, instruction=8'h00.
- Output values during and after reset: bus_oe=1, bus_out=0, sync=0, exec_strobe=0, phase=0.
- bus_out, bus_oe, sync, exec_strobe and phase are combinational decodes of the phase/pc registers; no added latency.
- A1: bus_out=pc[3:0]. A2: bus_out=pc[7:4]. A3: bus_out=pc[11:8]. Other phases: bus_out=0, bus_oe=0.
- Edge leaving A3: pc <= pc+1, 12-bit wrap (12'hFFF -> 12'h000).
- Edge leaving M1: instruction[7:4] <= bus_in.
- Edge leaving M2: instruction[3:0] <= bus_in.
- instruction is stable from X1 until the next M1 edge.
- exec_strobe=1 during X1 only; the byte is valid in that cycle.
- Flow requests are sampled only on the edge leaving X3. Priority: ret_req > call_req > jump_req. Requests in other phases are ignored.
- ret_req: sp <= (sp-1) mod STACK_DEPTH; pc <= stack[(sp-1) mod STACK_DEPTH].
- call_req: stack[sp] <= pc (already incremented = return address); sp <= (sp+1) mod STACK_DEPTH; pc <= jump_addr.
- jump_req: pc <= jump_addr.
- No request: pc unchanged.
- Stack overflow: the circular pointer overwrites the oldest entry; no flag.
- Stack underflow: returns whatever entry the pointer lands on; no flag.
- stall=1: phase, pc, instruction, stack and sp all hold, and outputs hold their decoded values.
- If stall is high on the X3 edge, requests are not consumed; they are re-sampled on the first non-stalled X3 edge.
- Stall in M1/M2 delays the bus capture to the non-stalled edge.
- Reset mid-cycle: immediate return to reset values; any partial fetch is discarded and the first cycle after release is A1 with pc=0.

Test Plan:
- Fetch from reset: release reset, bus_in=4'hD in M1 and 4'h5 in M2 -> bus_out 0,0,0 with bus_oe=1 in A1..A3; instruction=8'hD5 and exec_strobe=1 in X1; sync=1 in X3; pc=12'h001; next A1 bus_out=4'h1.
- PC wrap: jump_req with jump_addr=12'hFFF at X3 -> A1..A3 bus_out F,F,F; next cycle A1..A3 bus_out 0,0,0.
- Call/return: at pc=12'h006 (X3), call_req with jump_addr=12'h123 -> next cycle drives 3,2,1. Later ret_req at X3 -> following cycle drives 6,0,0 (pc=12'h006).
- Priority and overflow: ret_req+call_req together -> return taken, no push. Four consecutive calls returning 12'h010/020/030/040, then three rets -> pc 040, 030, 020; a fourth ret -> 040 (oldest overwritten).
- Stall: stall=1 for 3 cycles entering M1, bus_in changes 4'h1->4'hA while stalled, then stall=0 with bus_in=4'hA -> phase held at M1, instruction[7:4]=4'hA, exec_strobe delayed 3 cycles.
- Reset in X1 with pc=12'h0A7 -> phase=0, pc=0, instruction=8'h00, exec_strobe=0 immediately (before the next clock edge); stack cleared.
